// File: rtl/sof_tick_gen.sv
// Conditions the raw USB SOF strobe into a periodic 1 ms tick: locks onto the
// SOF grid, ignores glitch strobes, and fills in synthetic ticks across outages.
module sof_tick_gen #(
  parameter int unsigned PERIOD = 30720,
  parameter int unsigned TOL    = 64,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned HOLD_N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof_in,
  input  logic       miss_clr,
  output logic       tick_out,
  output logic       locked,
  output logic       holdover,
  output logic [7:0] miss_cnt
);

  localparam int unsigned GW = $clog2(LOCK_N + 1);
  localparam int unsigned HW = $clog2(HOLD_N + 1);
  localparam logic [15:0] WIN_LO  = 16'(PERIOD - TOL);
  localparam logic [15:0] WIN_HI  = 16'(PERIOD + TOL);
  localparam logic [15:0] SYN_RLD = 16'(TOL + 1);

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    per_cnt_q, per_cnt_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]     miss_cnt_q, miss_cnt_d;
  logic           tick_q, tick_d;
  logic           locked_q, holdover_q;

  logic           sof_good;
  logic           miss_hit;
  logic [GW-1:0]  good_inc;

  assign sof_good = sof_in && (per_cnt_q >= WIN_LO) && (per_cnt_q <= WIN_HI);
  assign miss_hit = !sof_in && (per_cnt_q == WIN_HI) && (state_q != ST_SEARCH);
  assign good_inc = good_cnt_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = (per_cnt_q == 16'hFFFF) ? per_cnt_q : per_cnt_q + 16'd1;
    good_cnt_d = good_cnt_q;
    hold_cnt_d = hold_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tick_d     = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (sof_in) begin
          tick_d    = 1'b1;
          per_cnt_d = 16'd1;
          if (sof_good) begin
            good_cnt_d = good_inc;
            if (good_inc == GW'(LOCK_N)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      ST_LOCKED, ST_HOLDOVER: begin
        // Early strobes fall through untouched, so the grid keeps running.
        if (sof_good) begin
          tick_d     = 1'b1;
          per_cnt_d  = 16'd1;
          hold_cnt_d = '0;
          state_d    = ST_LOCKED;
        end else if (miss_hit) begin
          tick_d    = 1'b1;
          per_cnt_d = SYN_RLD;
          if (state_q == ST_LOCKED) begin
            hold_cnt_d = HW'(1);
            state_d    = ST_HOLDOVER;
          end else if (hold_cnt_q < HW'(HOLD_N)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end else begin
            good_cnt_d = '0;
            hold_cnt_d = '0;
            state_d    = ST_SEARCH;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    if (miss_hit) begin
      if (miss_clr) begin
        miss_cnt_d = 8'd1;
      end else if (miss_cnt_q != 8'hFF) begin
        miss_cnt_d = miss_cnt_q + 8'd1;
      end
    end else if (miss_clr) begin
      miss_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      per_cnt_q  <= 16'hFFFF;
      good_cnt_q <= '0;
      hold_cnt_q <= '0;
      miss_cnt_q <= 8'd0;
      tick_q     <= 1'b0;
      locked_q   <= 1'b0;
      holdover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      good_cnt_q <= good_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      tick_q     <= tick_d;
      locked_q   <= (state_d == ST_LOCKED);
      holdover_q <= (state_d == ST_HOLDOVER);
    end
  end

  assign tick_out = tick_q;
  assign locked   = locked_q;
  assign holdover = holdover_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_sof_tick_gen.sv
// Self-checking bench for sof_tick_gen: directed scenarios plus random SOF
// traffic, scored every cycle against a timestamp-based reference model.
module tb_sof_tick_gen;

  localparam int P  = 64;
  localparam int T  = 8;
  localparam int LN = 4;
  localparam int HN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof_in;
  logic       miss_clr;
  logic       tick_out;
  logic       locked;
  logic       holdover;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int now    = 0;

  typedef enum {M_SEARCH, M_LOCKED, M_HOLD} mode_e;
  mode_e mMode     = M_SEARCH;
  int    mGoods    = 0;
  int    mHolds    = 0;
  int    mMisses   = 0;
  int    mEvtCyc   = 0;
  bit    mEvtValid = 1'b0;
  bit    mEvtSyn   = 1'b0;
  bit    mTick     = 1'b0;
  int    tickCyc[$];

  always #5 clk = ~clk;

  sof_tick_gen #(.PERIOD(P), .TOL(T), .LOCK_N(LN), .HOLD_N(HN)) dut (
    .clk      (clk),
    .rst      (rst),
    .sof_in   (sof_in),
    .miss_clr (miss_clr),
    .tick_out (tick_out),
    .locked   (locked),
    .holdover (holdover),
    .miss_cnt (miss_cnt)
  );

  // Interval seen at the current cycle: time since the last issued event,
  // with a synthetic event counting as if it had happened TOL cycles earlier.
  function automatic int elapsed();
    int e;
    if (!mEvtValid) return 65535;
    e = now - mEvtCyc + (mEvtSyn ? T : 0);
    if (e > 65535) e = 65535;
    return e;
  endfunction

  task automatic model_step(input bit s, input bit c, input bit r);
    int  e;
    bit  inWin;
    bit  missNow;
    mTick = 1'b0;
    if (r) begin
      mMode = M_SEARCH; mGoods = 0; mHolds = 0; mMisses = 0; mEvtValid = 1'b0;
      return;
    end
    e       = elapsed();
    inWin   = (e >= P - T) && (e <= P + T);
    missNow = !s && (mMode != M_SEARCH) && (e == P + T);
    if (mMode == M_SEARCH) begin
      if (s) begin
        mTick = 1'b1; mEvtValid = 1'b1; mEvtCyc = now; mEvtSyn = 1'b0;
        if (inWin) begin
          mGoods++;
          if (mGoods == LN) mMode = M_LOCKED;
        end else begin
          mGoods = 0;
        end
      end
    end else if (s && inWin) begin
      mTick = 1'b1; mEvtValid = 1'b1; mEvtCyc = now; mEvtSyn = 1'b0;
      mHolds = 0; mMode = M_LOCKED;
    end else if (missNow) begin
      mTick = 1'b1; mEvtValid = 1'b1; mEvtCyc = now; mEvtSyn = 1'b1;
      if (mMode == M_LOCKED) begin
        mHolds = 1; mMode = M_HOLD;
      end else if (mHolds < HN) begin
        mHolds++;
      end else begin
        mGoods = 0; mMode = M_SEARCH;
      end
    end
    if (missNow) mMisses = c ? 1 : ((mMisses < 255) ? mMisses + 1 : 255);
    else if (c)  mMisses = 0;
  endtask

  task automatic drive_cycle(input bit s, input bit c, input bit r);
    int cyc;
    cyc      = now;
    sof_in   = s;
    miss_clr = c;
    rst      = r;
    @(posedge clk);
    model_step(s, c, r);
    now++;
    #1;
    sof_in   = 1'b0;
    miss_clr = 1'b0;
    rst      = 1'b0;
    checks++;
    if (tick_out !== mTick || locked !== (mMode == M_LOCKED) ||
        holdover !== (mMode == M_HOLD) || miss_cnt !== 8'(mMisses)) begin
      errors++;
      $display("[TB] FAIL model cyc %0d: got tick=%b locked=%b holdover=%b miss_cnt=%0d, expected tick=%b locked=%b holdover=%b miss_cnt=%0d",
               cyc, tick_out, locked, holdover, miss_cnt,
               mTick, (mMode == M_LOCKED), (mMode == M_HOLD), mMisses);
    end
    if (tick_out === 1'b1) tickCyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_clr(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, (i == 0), 1'b0);
  endtask

  task automatic pulse();
    drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic relock();
    int k;
    k = 0;
    do begin
      idle(P - 1);
      pulse();
      k++;
    end while (locked !== 1'b1 && k < 10);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL relock: got locked=%b, expected 1", locked);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if ({tick_out, locked, holdover, miss_cnt} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, expected all zero",
               {tick_out, locked, holdover, miss_cnt});
    end
  endtask

  task automatic test_lock();
    int j;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        j = int'($urandom_range(2 * T)) - T;
        idle(P + j - 1);
      end
      pulse();
      checks++;
      if (tick_out !== 1'b1 || locked !== (i >= 4)) begin
        errors++;
        $display("[TB] FAIL lock_strobe%0d: got tick=%b locked=%b, expected tick=1 locked=%b",
                 i, tick_out, locked, (i >= 4));
      end
    end
    checks++;
    if (miss_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL lock_miss_cnt: got %0d, expected 0", miss_cnt);
    end
  endtask

  task automatic test_window_edges();
    idle(P - T - 1);
    pulse();
    checks++;
    if (tick_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL window_low_edge: got tick=%b, expected 1", tick_out);
    end
    idle(P + T - 1);
    pulse();
    checks++;
    if (tick_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL window_high_edge: got tick=%b, expected 1", tick_out);
    end
    idle_clr(P + T);
    checks++;
    if (tick_out !== 1'b1 || holdover !== 1'b1 || miss_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL window_overrun_synth: got tick=%b holdover=%b miss_cnt=%0d, expected 1 1 1",
               tick_out, holdover, miss_cnt);
    end
    pulse();
    checks++;
    if (tick_out !== 1'b0 || holdover !== 1'b1) begin
      errors++;
      $display("[TB] FAIL window_late_strobe: got tick=%b holdover=%b, expected 0 1",
               tick_out, holdover);
    end
    idle(P - T - 2);
    pulse();
    checks++;
    if (tick_out !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL window_recover: got tick=%b locked=%b, expected 1 1", tick_out, locked);
    end
  endtask

  task automatic test_glitch();
    int g;
    g = int'($urandom_range(P - T - 1, 2));
    idle(g - 1);
    pulse();
    checks++;
    if (tick_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_tick: got tick=%b at +%0d, expected 0", tick_out, g);
    end
    idle(P - g - 1);
    pulse();
    checks++;
    if (tick_out !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_next_sof: got tick=%b locked=%b, expected 1 1", tick_out, locked);
    end
  endtask

  task automatic test_holdover();
    int t;
    int expCyc[4];
    t = now - 1;
    expCyc = '{t + P + T, t + 2 * P + T, t + 3 * P + T, t + 4 * P};
    tickCyc.delete();
    idle_clr(4 * P - 1);
    pulse();
    checks++;
    if (tickCyc.size() != 4) begin
      errors++;
      $display("[TB] FAIL holdover_tick_count: got %0d, expected 4", tickCyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tickCyc[i] != expCyc[i]) begin
          errors++;
          $display("[TB] FAIL holdover_tick%0d_cycle: got %0d, expected %0d",
                   i, tickCyc[i], expCyc[i]);
        end
      end
    end
    checks++;
    if (miss_cnt !== 8'd3 || locked !== 1'b1 || holdover !== 1'b0) begin
      errors++;
      $display("[TB] FAIL holdover_recover: got miss_cnt=%0d locked=%b holdover=%b, expected 3 1 0",
               miss_cnt, locked, holdover);
    end
  endtask

  task automatic test_lock_loss();
    tickCyc.delete();
    idle_clr(9 * P + T + 2 * P);
    checks++;
    if (tickCyc.size() != 9 || locked !== 1'b0 || holdover !== 1'b0 || miss_cnt !== 8'd9) begin
      errors++;
      $display("[TB] FAIL lock_loss: got ticks=%0d locked=%b holdover=%b miss_cnt=%0d, expected 9 0 0 9",
               tickCyc.size(), locked, holdover, miss_cnt);
    end
    pulse();
    checks++;
    if (tick_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_loss_search_tick: got tick=%b, expected 1", tick_out);
    end
  endtask

  task automatic test_clear_coincident();
    relock();
    idle(P + T - 1);
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (tick_out !== 1'b1 || miss_cnt !== 8'd1 || holdover !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_coincident: got tick=%b miss_cnt=%0d holdover=%b, expected 1 1 1",
               tick_out, miss_cnt, holdover);
    end
  endtask

  task automatic test_random();
    int sel;
    int g;
    for (int ev = 0; ev < 200; ev++) begin
      sel = int'($urandom_range(99));
      if (sel < 70)      g = P - (T + 3) + int'($urandom_range(2 * T + 6));
      else if (sel < 85) g = 1 + int'($urandom_range(P - 2));
      else               g = P + int'($urandom_range(3 * P));
      for (int i = 0; i < g - 1; i++) drive_cycle(1'b0, ($urandom_range(49) == 0), 1'b0);
      drive_cycle(1'b1, ($urandom_range(49) == 0), 1'b0);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 29; r++) begin
      relock();
      idle(10 * P + T);
    end
    checks++;
    if (miss_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL miss_cnt_saturate: got %0d, expected 255", miss_cnt);
    end
  endtask

  task automatic test_reset_mid_holdover();
    relock();
    idle(P + T);
    checks++;
    if (holdover !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_holdover: got %b, expected 1", holdover);
    end
    idle(P - 1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if ({tick_out, locked, holdover, miss_cnt} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_holdover: got tick=%b locked=%b holdover=%b miss_cnt=%0d, expected all 0",
               tick_out, locked, holdover, miss_cnt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    sof_in   = 1'b0;
    miss_clr = 1'b0;
    test_reset();
    test_lock();
    test_window_edges();
    test_glitch();
    test_holdover();
    test_lock_loss();
    test_clear_coincident();
    test_random();
    test_saturation();
    test_reset_mid_holdover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
